// File: rtl/ppe_arb_pkg.sv
// Shared types, defaults and helpers for the PPE transaction arbiter.
package ppe_arb_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAX_BEATS = 16;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ppe_rr_picker.sv
// Combinational round-robin picker: nearest requester above last_id, wrapping.
module ppe_rr_picker
   import ppe_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]           req,
   input  logic [id_w(NUM_REQ)-1:0]     last_id,
   output logic                         found,
   output logic [id_w(NUM_REQ)-1:0]     id
);

   localparam int IW = id_w(NUM_REQ);

   logic [IW-1:0]          start;
   logic [2*NUM_REQ-1:0]   req_dbl;
   logic [NUM_REQ-1:0]     req_rot;
   logic [IW-1:0]          enc;
   logic [IW:0]            id_sum;

   // Search starts one past the previous winner, wrapping at NUM_REQ.
   assign start   = (last_id == IW'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
   assign req_dbl = {req, req};
   assign found   = |req;

   // Rotate so that the first candidate sits at bit 0.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign req_rot[gi] = req_dbl[gi + int'(start)];
   end

   // Lowest set bit of the rotated vector is the nearest requester.
   always_comb begin
      enc = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) enc = IW'(i);
      end
   end

   // Undo the rotation modulo NUM_REQ.
   assign id_sum = {1'b0, start} + {1'b0, enc};
   assign id     = (id_sum >= (IW+1)'(NUM_REQ)) ? IW'(id_sum - (IW+1)'(NUM_REQ))
                                                : id_sum[IW-1:0];

endmodule

// File: rtl/ppe_tx_arbiter.sv
// Round-robin burst arbiter sharing the PPE slave port among NUM_REQ masters.
// A grant is held from the first beat through the last beat of a burst.
module ppe_tx_arbiter
   import ppe_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BEATS = DEF_MAX_BEATS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            m_valid,
   input  logic [NUM_REQ-1:0]            m_last,
   input  logic [NUM_REQ*ADDR_W-1:0]     m_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     m_data,
   output logic [NUM_REQ-1:0]            m_ready,
   output logic                          s_valid,
   output logic                          s_last,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_data,
   output logic [id_w(NUM_REQ)-1:0]      s_id,
   input  logic                          s_ready,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          burst_err
);

   localparam int IW = id_w(NUM_REQ);
   localparam int CW = $clog2(MAX_BEATS + 1);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]       id_q, id_d;
   logic [IW-1:0]       last_id_q, last_id_d;
   logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
   logic                burst_err_q, burst_err_d;
   logic                busy_q, busy_d;

   logic                pick_found;
   logic [IW-1:0]       pick_id;
   logic                in_xfer;
   logic                hs;
   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
   logic [DATA_W-1:0]   data_arr [NUM_REQ];

   ppe_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req     (m_valid),
      .last_id (last_id_q),
      .found   (pick_found),
      .id      (pick_id)
   );

   // Unpack per-master slices and steer s_ready back to the granted master only.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mst
      assign addr_arr[gi] = m_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = m_data[gi*DATA_W +: DATA_W];
      assign m_ready[gi]  = grant_q[gi] & s_ready;
   end

   // Slave side is a zero-latency pass-through of the granted master.
   assign in_xfer   = (state_q == XFER);
   assign s_valid   = in_xfer & m_valid[id_q];
   assign s_last    = in_xfer & m_last[id_q];
   assign s_addr    = addr_arr[id_q];
   assign s_data    = data_arr[id_q];
   assign hs        = s_valid & s_ready;
   assign s_id      = id_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign burst_err = burst_err_q;

   // Next-state: grant on request in IDLE, release on the last handshake.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      id_d        = id_q;
      last_id_d   = last_id_q;
      beat_cnt_d  = beat_cnt_q;
      burst_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = XFER;
               grant_d    = NUM_REQ'(1) << pick_id;
               id_d       = pick_id;
               beat_cnt_d = '0;
            end
         end
         XFER: begin
            if (hs) begin
               if (s_last) begin
                  state_d    = IDLE;
                  grant_d    = '0;
                  last_id_d  = id_q;
                  beat_cnt_d = '0;
               end else begin
                  // Overlong bursts are flagged once, then the count saturates.
                  if (beat_cnt_q == CW'(MAX_BEATS - 1)) burst_err_d = 1'b1;
                  if (beat_cnt_q != CW'(MAX_BEATS))     beat_cnt_d  = beat_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == XFER);
   end

   // State registers; reset drops any burst in flight immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         id_q        <= '0;
         last_id_q   <= IW'(NUM_REQ - 1);
         beat_cnt_q  <= '0;
         burst_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         id_q        <= id_d;
         last_id_q   <= last_id_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_err_q <= burst_err_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_ppe_tx_arbiter.sv
// Bench for ppe_tx_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_ppe_tx_arbiter;

   localparam int NR   = 4;
   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int MAXB = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     m_valid, m_last, m_ready, grant;
   logic [NR*AW-1:0]  m_addr;
   logic [NR*DW-1:0]  m_data;
   logic              s_valid, s_last, s_ready, busy, burst_err;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_data;
   logic [1:0]        s_id;

   always #5 clk = ~clk;

   ppe_tx_arbiter #(
      .NUM_REQ   (NR),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MAX_BEATS (MAXB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_addr    (m_addr),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_addr    (s_addr),
      .s_data    (s_data),
      .s_id      (s_id),
      .s_ready   (s_ready),
      .grant     (grant),
      .busy      (busy),
      .burst_err (burst_err)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Master-side traffic state: remaining beats, beat index, burst tag, idle gap.
   int rem [NR];
   int beat [NR];
   int burst_no [NR];
   bit gap [NR];

   // Reference model: arbitration outcome at transaction level.
   int mdl_busy, mdl_id, mdl_sid, mdl_last, mdl_cnt, mdl_err;

   // Observations for scenario-level checks.
   int gq [$];
   bit prev_g;
   int hs_cnt, err_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic bit mvalid(input int i);
      return (rem[i] > 0) && !gap[i];
   endfunction

   function automatic logic [AW-1:0] exp_addr(input int i);
      return AW'(i * 4096 + beat[i]);
   endfunction

   function automatic logic [DW-1:0] exp_data(input int i);
      return {8'(i), 8'(burst_no[i]), 16'(beat[i] * 3 + 7)};
   endfunction

   function automatic bit any_pending();
      bit p = 1'b0;
      for (int i = 0; i < NR; i++) if (rem[i] > 0) p = 1'b1;
      return p;
   endfunction

   task automatic start_burst(input int i, input int len);
      rem[i]  = len;
      beat[i] = 0;
      burst_no[i]++;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NR; i++) begin
         m_valid[i]            = mvalid(i);
         m_last[i]             = (rem[i] == 1);
         m_addr[i*AW +: AW]    = exp_addr(i);
         m_data[i*DW +: DW]    = exp_data(i);
      end
   endtask

   task automatic check_outputs();
      logic [NR-1:0] eg, er;
      bit esv;
      eg  = mdl_busy ? (NR'(1) << mdl_id) : '0;
      er  = mdl_busy ? (NR'(s_ready) << mdl_id) : '0;
      esv = (mdl_busy != 0) && mvalid(mdl_id);
      chk("grant", grant, eg);
      chk("busy", busy, mdl_busy);
      chk("s_id", s_id, mdl_sid);
      chk("s_valid", s_valid, esv);
      chk("m_ready", m_ready, er);
      chk("burst_err", burst_err, mdl_err);
      if (esv) begin
         chk("s_addr", s_addr, exp_addr(mdl_id));
         chk("s_data", s_data, exp_data(mdl_id));
         chk("s_last", s_last, rem[mdl_id] == 1);
      end
      if (grant != 0 && !prev_g) gq.push_back(int'(s_id));
      prev_g = (grant != 0);
      if (s_valid && s_ready) hs_cnt++;
      if (burst_err) err_cnt++;
   endtask

   // Advance the model across one rising edge.
   task automatic model_step();
      int  nerr = 0;
      bit  hs, found;
      int  c, g;
      hs = (mdl_busy != 0) && mvalid(mdl_id) && s_ready;
      if (mdl_busy == 0) begin
         found = 1'b0;
         for (int k = 1; k <= NR; k++) begin
            c = (mdl_last + k) % NR;
            if (!found && mvalid(c)) begin
               found    = 1'b1;
               mdl_busy = 1;
               mdl_id   = c;
               mdl_sid  = c;
               mdl_cnt  = 0;
            end
         end
      end else if (hs) begin
         g = mdl_id;
         rem[g]--;
         beat[g]++;
         if (rem[g] == 0) begin
            mdl_busy = 0;
            mdl_last = g;
            mdl_cnt  = 0;
            $display("burst done: master=%0d beats=%0d tag=%0d", g, beat[g], burst_no[g]);
         end else begin
            if (mdl_cnt == MAXB - 1) nerr = 1;
            if (mdl_cnt < MAXB) mdl_cnt++;
         end
      end
      mdl_err = nerr;
   endtask

   // One clock cycle: drive after the edge, check mid-cycle, step the model.
   task automatic cycle(input bit rdy);
      s_ready = rdy;
      drive_inputs();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_m_ready", m_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_burst_err", burst_err, 0);
      chk("rst_s_id", s_id, 0);
      for (int i = 0; i < NR; i++) begin
         rem[i]  = 0;
         beat[i] = 0;
         gap[i]  = 1'b0;
      end
      s_ready  = 1'b0;
      drive_inputs();
      mdl_busy = 0;
      mdl_id   = 0;
      mdl_sid  = 0;
      mdl_last = NR - 1;
      mdl_cnt  = 0;
      mdl_err  = 0;
      prev_g   = 1'b0;
      gq.delete();
      hs_cnt   = 0;
      err_cnt  = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_quiet(input int maxc, input int mode, input string tag);
      int n = 0;
      bit rdy;
      while ((any_pending() || mdl_busy != 0) && n < maxc) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (n % 4 == 0) || (n % 4 == 3);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         cycle(rdy);
         n++;
      end
      chk({tag, "_done_in_budget"}, n < maxc, 1);
      cycle(1'b1);
   endtask

   initial begin
      int n;
      rst     = 1'b0;
      s_ready = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rem[i] = 0; beat[i] = 0; burst_no[i] = 0; gap[i] = 1'b0;
      end
      drive_inputs();
      @(posedge clk);
      #1;

      // Single master: master 2, three beats.
      do_reset();
      start_burst(2, 3);
      run_until_quiet(20, 0, "t1");
      chk("t1_handshakes", hs_cnt, 3);
      chk("t1_grants", gq.size(), 1);
      chk("t1_grant_id", gq[0], 2);

      // All four request continuously with one-beat bursts.
      do_reset();
      for (int i = 0; i < NR; i++) start_burst(i, 1);
      n = 0;
      while (gq.size() < 5 && n < 40) begin
         cycle(1'b1);
         for (int i = 0; i < NR; i++) if (rem[i] == 0) start_burst(i, 1);
         n++;
      end
      chk("t2_done_in_budget", n < 40, 1);
      chk("t2_order0", gq[0], 0);
      chk("t2_order1", gq[1], 1);
      chk("t2_order2", gq[2], 2);
      chk("t2_order3", gq[3], 3);
      chk("t2_order4", gq[4], 0);

      // Backpressure on master 1; master 3 arrives during its burst.
      do_reset();
      start_burst(1, 4);
      cycle(1'b1);
      start_burst(3, 1);
      run_until_quiet(60, 1, "t3");
      chk("t3_handshakes", hs_cnt, 5);
      chk("t3_grants", gq.size(), 2);
      chk("t3_first", gq[0], 1);
      chk("t3_second", gq[1], 3);

      // Overlong burst: six beats against a limit of four.
      do_reset();
      start_burst(0, 6);
      run_until_quiet(30, 0, "t4");
      chk("t4_handshakes", hs_cnt, 6);
      chk("t4_err_pulses", err_cnt, 1);
      chk("t4_grants", gq.size(), 1);

      // Random traffic with gaps and random backpressure.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 3) == 0) start_burst(i, $urandom_range(1, 6));
            gap[i] = ($urandom_range(0, 4) == 0);
         end
         cycle($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < NR; i++) gap[i] = 1'b0;
      run_until_quiet(400, 2, "rand_drain");

      // Reset in the middle of a master 3 burst, then 0 and 3 together.
      do_reset();
      start_burst(3, 4);
      n = 0;
      while (beat[3] < 1 && n < 10) begin
         cycle(1'b1);
         n++;
      end
      chk("t5_reached_beat2", n < 10, 1);
      drive_inputs();
      chk("t5_busy_before_rst", busy, 1);
      do_reset();
      start_burst(0, 2);
      start_burst(3, 2);
      run_until_quiet(30, 0, "t5");
      chk("t5_grants", gq.size(), 2);
      chk("t5_first", gq[0], 0);
      chk("t5_second", gq[1], 3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
